// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared definitions for the ALU execute controller and for decode.
//   - Opcode values (NOP=0 ... BSR=65) and the range boundaries of each op class.
//   - CCR bit indices and a helper that packs the four ALU flags plus INR.
//   - Controller state enum, op-class enum and branch-condition enum.
// No ports. Optional feature macro used by the controller: ALU_CTRL_ISSUE_BUF_EN.
package alu_ctrl_pkg;

    // Opcodes. Ops 1..13 are register/register writebacks; 14 and 32..38 take the
    // immediate as RB.
    localparam int unsigned OP_NOP     = 0;
    localparam int unsigned OP_ADD     = 1;
    localparam int unsigned OP_RR_LAST = 13;
    localparam int unsigned OP_ADDQ    = 14;
    localparam int unsigned OP_LDR     = 15;
    localparam int unsigned OP_JMP     = 16;
    localparam int unsigned OP_JSR     = 17;
    localparam int unsigned OP_RTS     = 18;
    localparam int unsigned OP_ADDI    = 32;
    localparam int unsigned OP_RI_LAST = 38;
    localparam int unsigned OP_BEQ     = 39;
    localparam int unsigned OP_BNE     = 40;
    localparam int unsigned OP_BLT     = 41;
    localparam int unsigned OP_LDI     = 42;
    localparam int unsigned OP_STI     = 43;
    localparam int unsigned OP_LDIX    = 44;
    localparam int unsigned OP_STIX    = 45;
    localparam int unsigned OP_BRA     = 64;
    localparam int unsigned OP_BSR     = 65;

    // CCR layout; bits above INR always read zero.
    localparam int unsigned CCR_W   = 32;
    localparam int unsigned CCR_C   = 0;
    localparam int unsigned CCR_V   = 1;
    localparam int unsigned CCR_Z   = 2;
    localparam int unsigned CCR_N   = 3;
    localparam int unsigned CCR_INR = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StExec,
        StRetire
    } state_e;

    typedef enum logic [2:0] {
        ClsNop,
        ClsWb,
        ClsLoad,
        ClsStore,
        ClsBrCond,
        ClsJump,
        ClsIllegal
    } op_class_e;

    typedef enum logic [2:0] {
        BrNone,
        BrEq,
        BrNe,
        BrLt,
        BrAlways
    } br_cond_e;

    function automatic logic [CCR_W-1:0] ccr_pack(input logic n, input logic z,
                                                  input logic v, input logic c,
                                                  input logic inr);
        logic [CCR_W-1:0] p;
        p          = '0;
        p[CCR_C]   = c;
        p[CCR_V]   = v;
        p[CCR_Z]   = z;
        p[CCR_N]   = n;
        p[CCR_INR] = inr;
        return p;
    endfunction

endpackage

// File: rtl/alu_op_classifier.sv
// alu_op_classifier: purely combinational opcode decoder, shared with decode.
// Ports:
//   op       in   OP_W  opcode
//   op_class out  enum  writeback / load / store / conditional branch / jump / nop / illegal
//   imm_sel  out  1     RB operand comes from the immediate
//   br_cond  out  enum  branch condition for branch and jump classes
module alu_op_classifier
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned OP_W = 7
) (
    input  logic [OP_W-1:0] op,
    output op_class_e       op_class,
    output logic            imm_sel,
    output br_cond_e        br_cond
);

    logic [31:0] op_ext;
    assign op_ext = 32'(op);

    always_comb begin
        op_class = ClsIllegal;
        imm_sel  = 1'b0;
        br_cond  = BrNone;
        case (op_ext) inside
            OP_NOP:                  op_class = ClsNop;
            [OP_ADD:OP_RR_LAST]:     op_class = ClsWb;
            OP_ADDQ, [OP_ADDI:OP_RI_LAST]: begin
                op_class = ClsWb;
                imm_sel  = 1'b1;
            end
            OP_LDR:                  op_class = ClsLoad;
            OP_LDI, OP_LDIX: begin
                op_class = ClsLoad;
                imm_sel  = 1'b1;
            end
            OP_STI, OP_STIX: begin
                op_class = ClsStore;
                imm_sel  = 1'b1;
            end
            OP_BEQ: begin
                op_class = ClsBrCond;
                br_cond  = BrEq;
            end
            OP_BNE: begin
                op_class = ClsBrCond;
                br_cond  = BrNe;
            end
            OP_BLT: begin
                op_class = ClsBrCond;
                br_cond  = BrLt;
            end
            OP_JMP, OP_JSR, OP_RTS, OP_BRA, OP_BSR: begin
                op_class = ClsJump;
                br_cond  = BrAlways;
            end
            default: op_class = ClsIllegal;
        endcase
    end

endmodule

// File: rtl/alu_execute_controller.sv
// alu_execute_controller: multi-cycle sequencer owning the shared ALU and the CCR.
// Sequence per instruction: IDLE (accept, present RF addresses) -> READ (capture RF data)
// -> EXEC (drive ALU, register RZ and flags) -> RETIRE (one strobe, CCR update).
// Ports:
//   clk, rst                         clock (rising edge), asynchronous active-high reset
//   issue_valid/ready/op/rd/ra/rb/imm  instruction handshake from the issue stage
//   rf_ra_addr/rf_rb_addr, rf_ra_data/rf_rb_data  register-file read (data one cycle later)
//   alu_op/alu_ra/alu_rb, alu_rz, alu_n/z/v/c     shared ALU interface (driven only in EXEC)
//   rf_wr_en/rf_wr_addr/rf_wr_data   writeback strobe
//   agu_valid/agu_addr/agu_store     address strobe for loads and stores
//   br_valid/br_taken                control-flow decision strobe
//   ccr                              condition control register {27'b0, INR, N, Z, V, C}
//   busy                             controller not idle
// Optional macro ALU_CTRL_ISSUE_BUF_EN adds a one-entry issue buffer so that an instruction
// accepted while busy launches straight from RETIRE into READ.
module alu_execute_controller
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 4,
    parameter int unsigned OP_W   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [OP_W-1:0]   issue_op,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic [REG_AW-1:0] issue_ra,
    input  logic [REG_AW-1:0] issue_rb,
    input  logic [DATA_W-1:0] issue_imm,
    output logic [REG_AW-1:0] rf_ra_addr,
    output logic [REG_AW-1:0] rf_rb_addr,
    input  logic [DATA_W-1:0] rf_ra_data,
    input  logic [DATA_W-1:0] rf_rb_data,
    output logic [31:0]       alu_op,
    output logic [DATA_W-1:0] alu_ra,
    output logic [DATA_W-1:0] alu_rb,
    input  logic [DATA_W-1:0] alu_rz,
    input  logic              alu_n,
    input  logic              alu_z,
    input  logic              alu_v,
    input  logic              alu_c,
    output logic              rf_wr_en,
    output logic [REG_AW-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              agu_valid,
    output logic [DATA_W-1:0] agu_addr,
    output logic              agu_store,
    output logic              br_valid,
    output logic              br_taken,
    output logic [31:0]       ccr,
    output logic              busy
);

    state_e state_q, state_d;

    logic [OP_W-1:0]   op_q;
    logic [REG_AW-1:0] rd_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] opa_q, opb_q;
    logic [DATA_W-1:0] rz_q;
    logic              n_q, z_q, v_q, c_q;
    logic [CCR_W-1:0]  ccr_q, ccr_d;

    // Launch = an instruction enters READ on the next edge; its RF addresses go out now.
    logic              launch_issue;
    logic              launch_buf;
    logic              launch;
    logic [OP_W-1:0]   ln_op;
    logic [REG_AW-1:0] ln_rd, ln_ra, ln_rb;
    logic [DATA_W-1:0] ln_imm;

    op_class_e op_class;
    logic      imm_sel;
    br_cond_e  br_cond;

    alu_op_classifier #(
        .OP_W (OP_W)
    ) u_classifier (
        .op       (op_q),
        .op_class (op_class),
        .imm_sel  (imm_sel),
        .br_cond  (br_cond)
    );

`ifdef ALU_CTRL_ISSUE_BUF_EN
    logic              buf_valid_q;
    logic [OP_W-1:0]   buf_op_q;
    logic [REG_AW-1:0] buf_rd_q, buf_ra_q, buf_rb_q;
    logic [DATA_W-1:0] buf_imm_q;
    logic              buf_fill;

    assign issue_ready = (state_q == StIdle) || !buf_valid_q;
    // An empty buffer in RETIRE lets a new instruction bypass straight into READ.
    assign launch_issue = issue_valid &&
                          ((state_q == StIdle) || ((state_q == StRetire) && !buf_valid_q));
    assign launch_buf   = (state_q == StRetire) && buf_valid_q;
    assign buf_fill     = issue_valid && !buf_valid_q &&
                          ((state_q == StRead) || (state_q == StExec));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            buf_op_q    <= '0;
            buf_rd_q    <= '0;
            buf_ra_q    <= '0;
            buf_rb_q    <= '0;
            buf_imm_q   <= '0;
        end else if (buf_fill) begin
            buf_valid_q <= 1'b1;
            buf_op_q    <= issue_op;
            buf_rd_q    <= issue_rd;
            buf_ra_q    <= issue_ra;
            buf_rb_q    <= issue_rb;
            buf_imm_q   <= issue_imm;
        end else if (launch_buf) begin
            buf_valid_q <= 1'b0;
        end
    end

    always_comb begin
        ln_op  = issue_op;
        ln_rd  = issue_rd;
        ln_ra  = issue_ra;
        ln_rb  = issue_rb;
        ln_imm = issue_imm;
        if (launch_buf) begin
            ln_op  = buf_op_q;
            ln_rd  = buf_rd_q;
            ln_ra  = buf_ra_q;
            ln_rb  = buf_rb_q;
            ln_imm = buf_imm_q;
        end
    end
`else
    assign issue_ready  = (state_q == StIdle);
    assign launch_issue = issue_valid && (state_q == StIdle);
    assign launch_buf   = 1'b0;

    always_comb begin
        ln_op  = issue_op;
        ln_rd  = issue_rd;
        ln_ra  = issue_ra;
        ln_rb  = issue_rb;
        ln_imm = issue_imm;
    end
`endif

    assign launch     = launch_issue || launch_buf;
    assign rf_ra_addr = launch ? ln_ra : '0;
    assign rf_rb_addr = launch ? ln_rb : '0;
    assign busy       = (state_q != StIdle);
    assign ccr        = ccr_q;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (launch) state_d = StRead;
            StRead:   state_d = StExec;
            StExec:   state_d = StRetire;
            StRetire: state_d = launch ? StRead : StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers. Flags are sampled in EXEC only, so ALU activity in other
    // states never reaches the CCR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q  <= '0;
            rd_q  <= '0;
            imm_q <= '0;
            opa_q <= '0;
            opb_q <= '0;
            rz_q  <= '0;
            n_q   <= 1'b0;
            z_q   <= 1'b0;
            v_q   <= 1'b0;
            c_q   <= 1'b0;
            ccr_q <= '0;
        end else begin
            if (launch) begin
                op_q  <= ln_op;
                rd_q  <= ln_rd;
                imm_q <= ln_imm;
            end
            if (state_q == StRead) begin
                opa_q <= rf_ra_data;
                opb_q <= rf_rb_data;
            end
            if (state_q == StExec) begin
                rz_q <= alu_rz;
                n_q  <= alu_n;
                z_q  <= alu_z;
                v_q  <= alu_v;
                c_q  <= alu_c;
            end
            ccr_q <= ccr_d;
        end
    end

    // ALU drive, retire strobes and CCR next value. All outputs idle at zero.
    always_comb begin
        alu_op     = '0;
        alu_ra     = '0;
        alu_rb     = '0;
        rf_wr_en   = 1'b0;
        rf_wr_addr = '0;
        rf_wr_data = '0;
        agu_valid  = 1'b0;
        agu_addr   = '0;
        agu_store  = 1'b0;
        br_valid   = 1'b0;
        br_taken   = 1'b0;
        ccr_d      = ccr_q;
        case (state_q)
            StExec: begin
                alu_op = 32'(op_q);
                alu_ra = opa_q;
                alu_rb = imm_sel ? imm_q : opb_q;
            end
            StRetire: begin
                case (op_class)
                    ClsWb: begin
                        rf_wr_en   = 1'b1;
                        rf_wr_addr = rd_q;
                        rf_wr_data = rz_q;
                    end
                    ClsLoad: begin
                        agu_valid = 1'b1;
                        agu_addr  = rz_q;
                    end
                    ClsStore: begin
                        agu_valid = 1'b1;
                        agu_addr  = rz_q;
                        agu_store = 1'b1;
                    end
                    ClsBrCond, ClsJump: begin
                        br_valid = 1'b1;
                        case (br_cond)
                            BrEq:     br_taken = z_q;
                            BrNe:     br_taken = !z_q;
                            BrLt:     br_taken = n_q;
                            BrAlways: br_taken = 1'b1;
                            default:  br_taken = 1'b0;
                        endcase
                    end
                    default: ;
                endcase
                // Any recognised non-NOP op reloads all flags and clears INR.
                case (op_class)
                    ClsNop:     ccr_d = ccr_q;
                    ClsIllegal: ccr_d[CCR_INR] = 1'b1;
                    default:    ccr_d = ccr_pack(n_q, z_q, v_q, c_q, 1'b0);
                endcase
            end
            default: ;
        endcase
    end

endmodule
